// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: count byte, 4*N little-endian data bytes,
// XOR checksum; releases the CPU only after a complete, verified frame.
module imem_loader #(
    parameter logic [7:0]  BASE_ADDR    = 8'd0,
    parameter int unsigned IDLE_TIMEOUT = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_run,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned TW = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [8:0]    idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_ready_q, in_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          cpu_run_q, cpu_run_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          accept_s;
    logic [TW-1:0] tmo_inc_s;
    logic [31:0]   word_shift_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        word_d       = word_q;
        bcnt_d       = bcnt_q;
        csum_d       = csum_q;
        tmo_d        = tmo_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        accept_s     = in_valid & in_ready_q;
        tmo_inc_s    = tmo_q + TW'(1);
        word_shift_s = {in_byte, word_q[31:8]};

        case (state_q)
            ST_COUNT: begin
                if (accept_s) begin
                    cnt_d   = (in_byte == 8'd0) ? 9'd256 : {1'b0, in_byte};
                    idx_d   = 9'd0;
                    csum_d  = 8'd0;
                    bcnt_d  = 2'd0;
                    word_d  = 32'd0;
                    tmo_d   = TW'(0);
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    word_d = word_shift_s;
                    csum_d = csum_q ^ in_byte;
                    bcnt_d = bcnt_q + 2'd1;
                    tmo_d  = TW'(0);
                    if (bcnt_q == 2'd3) begin
                        state_d   = ST_WRITE;
                        wr_addr_d = BASE_ADDR + idx_q[7:0];
                        wr_data_d = word_shift_s;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    tmo_d = tmo_inc_s;
                    if (tmo_inc_s == TMO_LIMIT) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + 9'd1;
                if ((idx_q + 9'd1) == cnt_q) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_DATA;
                    tmo_d   = TW'(0);
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    tmo_d   = TW'(0);
                    state_d = (in_byte == csum_q) ? ST_DONE : ST_ERROR;
                end else begin
                    tmo_d = tmo_inc_s;
                    if (tmo_inc_s == TMO_LIMIT) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        // Outputs follow the state being entered so they line up with it.
        in_ready_d = 1'b0;
        wr_en_d    = 1'b0;
        cpu_run_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_d)
            ST_COUNT, ST_DATA, ST_CHECK: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            ST_WRITE: begin
                wr_en_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_DONE: begin
                cpu_run_d = 1'b1;
                done_d    = 1'b1;
            end
            ST_ERROR: error_d = 1'b1;
            default:  error_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_COUNT;
            cnt_q      <= 9'd0;
            idx_q      <= 9'd0;
            word_q     <= 32'd0;
            bcnt_q     <= 2'd0;
            csum_q     <= 8'd0;
            tmo_q      <= TW'(0);
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 32'd0;
            cpu_run_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_run_q  <= cpu_run_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_run  = cpu_run_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench for imem_loader: two instances (base 00 and FF) share one
// byte stream; writes are collected and compared with words computed from the frame.
module tb_imem_loader;

    localparam int TO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;

    logic        in_ready0, wr_en0, cpu_run0, busy0, done0, error0;
    logic [7:0]  wr_addr0;
    logic [31:0] wr_data0;
    logic        in_ready1, wr_en1, cpu_run1, busy1, done1, error1;
    logic [7:0]  wr_addr1;
    logic [31:0] wr_data1;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    logic [39:0] q0[$];
    logic [39:0] q1[$];
    logic [7:0]  dat[$];

    imem_loader #(.BASE_ADDR(8'h00), .IDLE_TIMEOUT(TO)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .cpu_run(cpu_run0), .busy(busy0), .done(done0), .error(error0));

    imem_loader #(.BASE_ADDR(8'hFF), .IDLE_TIMEOUT(TO)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .cpu_run(cpu_run1), .busy(busy1), .done(done1), .error(error1));

    always #5 clock = ~clock;

    // Write collector and per-cycle WRITE-state sanity observer.
    always @(negedge clock) begin
        if (wr_en0) q0.push_back({wr_addr0, wr_data0});
        if (wr_en1) q1.push_back({wr_addr1, wr_data1});
        if (wr_en0 && (in_ready0 || cpu_run0)) viol++;
        if (wr_en1 && (in_ready1 || cpu_run1)) viol++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_outs0", {in_ready0, wr_en0, wr_addr0, wr_data0, cpu_run0, busy0, done0, error0},
            {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
        chk("rst_outs1", {in_ready1, wr_en1, wr_addr1, wr_data1, cpu_run1, busy1, done1, error1},
            {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        int n;
        gap = $urandom_range(0, 2);
        n   = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready0 && n < 8) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready0) chk("ready_wait_expired", {63'd0, in_ready0}, 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int nw, input bit good, input bit with_rst);
        logic [7:0]  x;
        logic [7:0]  cs;
        logic [31:0] w;
        if (with_rst) begin
            do_reset();
            q0.delete();
            q1.delete();
        end
        if (dat.size() == 0) begin
            for (int i = 0; i < 4 * nw; i++) dat.push_back(8'($urandom));
        end
        x = 8'h00;
        for (int i = 0; i < dat.size(); i++) x = x ^ dat[i];
        cs = good ? x : (x ^ 8'($urandom_range(1, 255)));
        send_byte(8'(nw));
        for (int i = 0; i < dat.size(); i++) send_byte(dat[i]);
        chk("pre_check_hold", {61'd0, busy0, cpu_run0, done0}, 64'b100);
        send_byte(cs);
        repeat (3) @(negedge clock);
        chk("end_state0", {59'd0, done0, error0, cpu_run0, in_ready0, busy0},
            good ? 64'b10100 : 64'b01000);
        chk("end_state1", {59'd0, done1, error1, cpu_run1, in_ready1, busy1},
            good ? 64'b10100 : 64'b01000);
        chk("num_writes0", q0.size(), nw);
        chk("num_writes1", q1.size(), nw);
        for (int k = 0; k < nw; k++) begin
            w = {dat[4*k+3], dat[4*k+2], dat[4*k+1], dat[4*k]};
            if (k < q0.size()) chk("write0", q0[k], {8'(k), w});
            if (k < q1.size()) chk("write1", q1[k], {8'(8'hFF + k), w});
        end
        dat.delete();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;

        // Known frame: one word 12345678, checksum 08.
        dat.push_back(8'h78); dat.push_back(8'h56); dat.push_back(8'h34); dat.push_back(8'h12);
        run_frame(1, 1'b1, 1'b1);
        chk("known_word", (q0.size() > 0) ? {24'd0, q0[0]} : 64'd0, {24'd0, 8'h00, 32'h12345678});

        // Two words, wrong checksum; base FF instance wraps FF -> 00.
        run_frame(2, 1'b0, 1'b1);

        for (int r = 0; r < 5; r++) begin
            run_frame($urandom_range(1, 9), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Idle timeout after the 2nd data byte.
        do_reset();
        q0.delete();
        q1.delete();
        send_byte(8'd1);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        repeat (TO - 1) @(negedge clock);
        chk("tmo_not_yet", {62'd0, busy0, error0}, 64'b10);
        @(negedge clock);
        chk("tmo_error", {60'd0, error0, cpu_run0, in_ready0, busy0}, 64'b1000);
        chk("tmo_no_write", q0.size(), 0);

        // Reset after the 3rd byte of the first word, then a clean frame.
        do_reset();
        q0.delete();
        q1.delete();
        send_byte(8'd2);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        do_reset();
        repeat (3) @(negedge clock);
        chk("midword_no_write", q0.size(), 0);
        run_frame(3, 1'b1, 1'b0);

        // N = 0 means 256 words.
        run_frame(256, 1'b1, 1'b1);

        chk("write_state_outputs", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
